// File: rtl/ro_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: counts synchronised rising edges per
// channel over a programmable gate window of clk cycles and latches one result per channel.
module ro_freq_meter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 12
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             ena,
  input  logic [NUM_CH-1:0]                                ro_in,
  input  logic [GATE_W-1:0]                                gate_len,
  input  logic                                             start,
  input  logic                                             cont,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   rd_ch,
  output logic [CNT_W-1:0]                                 rd_data,
  output logic                                             rd_ovf,
  output logic                                             busy,
  output logic                                             done,
  output logic [7:0]                                       meas_id
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;

  state_t              state_reg;
  logic [GATE_W-1:0]   gate_cnt_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [7:0]          meas_id_reg;
  logic [CNT_W-1:0]    rd_data_reg;
  logic                rd_ovf_reg;

  logic [NUM_CH-1:0]   sync1_reg;
  logic [NUM_CH-1:0]   sync2_reg;
  logic [NUM_CH-1:0]   sync3_reg;
  logic [NUM_CH-1:0]   edge_det;

  logic [CNT_W-1:0]    res_arr [NUM_CH];
  logic [NUM_CH-1:0]   res_ovf;

  // Two-flop synchroniser plus a history flop; runs regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      sync3_reg <= '0;
    end else begin
      sync1_reg <= ro_in;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  assign edge_det = sync2_reg & ~sync3_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gate_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      meas_id_reg  <= 8'd0;
    end else begin
      done_reg <= 1'b0;
      if (!ena) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && (gate_len != '0)) begin
              state_reg <= ARM;
              busy_reg  <= 1'b1;
            end
          end
          ARM: begin
            gate_cnt_reg <= gate_len;
            state_reg    <= GATE;
          end
          GATE: begin
            // Leaving on a count of 1 makes the window exactly gate_len cycles long.
            gate_cnt_reg <= gate_cnt_reg - GATE_W'(1);
            if (gate_cnt_reg == GATE_W'(1)) begin
              state_reg <= LATCH;
            end
          end
          LATCH: begin
            done_reg    <= 1'b1;
            meas_id_reg <= meas_id_reg + 8'd1;
            if (cont) begin
              state_reg <= ARM;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : ch_g
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;
    logic [CNT_W-1:0] res_reg;
    logic             res_ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg     <= '0;
        ovf_reg     <= 1'b0;
        res_reg     <= '0;
        res_ovf_reg <= 1'b0;
      end else begin
        if (!ena || (state_reg == ARM)) begin
          cnt_reg <= '0;
          ovf_reg <= 1'b0;
        end else if ((state_reg == GATE) && edge_det[gi]) begin
          // Saturate at all-ones and remember that an edge was lost.
          if (&cnt_reg) begin
            ovf_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        if (ena && (state_reg == LATCH)) begin
          res_reg     <= cnt_reg;
          res_ovf_reg <= ovf_reg;
        end
      end
    end

    assign res_arr[gi] = res_reg;
    assign res_ovf[gi] = res_ovf_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
      rd_ovf_reg  <= 1'b0;
    end else if (32'(rd_ch) < NUM_CH) begin
      rd_data_reg <= res_arr[rd_ch];
      rd_ovf_reg  <= res_ovf[rd_ch];
    end else begin
      rd_data_reg <= '0;
      rd_ovf_reg  <= 1'b0;
    end
  end

  assign rd_data = rd_data_reg;
  assign rd_ovf  = rd_ovf_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign meas_id = meas_id_reg;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Randomised bench for ro_freq_meter: window edge counts come from logged stimulus edge
// timestamps; expected results are queued and checked when done appears.
module tb_ro_freq_meter;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 5;
  localparam int GATE_W = 8;
  localparam int RD_W   = 2;
  localparam int MAXC   = 65536;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              ena      = 1'b0;
  logic [NUM_CH-1:0] ro_in    = '0;
  logic [GATE_W-1:0] gate_len = '0;
  logic              start    = 1'b0;
  logic              cont     = 1'b0;
  logic [RD_W-1:0]   rd_ch    = '0;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_ovf;
  logic              busy;
  logic              done;
  logic [7:0]        meas_id;

  ro_freq_meter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .gate_len(gate_len),
    .start(start), .cont(cont), .rd_ch(rd_ch), .rd_data(rd_data), .rd_ovf(rd_ovf),
    .busy(busy), .done(done), .meas_id(meas_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // rose[ch][n]: stimulus drove a 0->1 on ro_in[ch] just after posedge n.
  bit rose [NUM_CH][MAXC];
  int mode [NUM_CH];
  int per  [NUM_CH];
  int ph   [NUM_CH];
  bit stat [NUM_CH];

  int b_start  = 1;
  int b_end    = 0;
  int model_id = 0;

  int                        q_due [$];
  int                        q_id  [$];
  logic [NUM_CH*CNT_W-1:0]   q_cnt [$];
  logic [NUM_CH-1:0]         q_ovf [$];

  logic [CNT_W-1:0] exp_res [NUM_CH];
  bit               exp_ovf [NUM_CH];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  task automatic drive_ro(input int n);
    int v;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      case (mode[ch])
        0:       v = int'(stat[ch]);
        1:       v = ((n + ph[ch]) / per[ch]) % 2;
        default: v = int'($urandom_range(0, 1));
      endcase
      if ((v != 0) && !ro_in[ch] && (n < MAXC)) rose[ch][n] = 1'b1;
      ro_in[ch] = (v != 0);
    end
  endtask

  task automatic rand_modes();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      mode[ch] = int'($urandom_range(0, 2));
      per[ch]  = int'($urandom_range(1, 7));
      ph[ch]   = int'($urandom_range(0, 13));
      stat[ch] = bit'($urandom_range(0, 1));
    end
  endtask

  // Window of run starting at ARM edge er covers stimulus edges driven after posedges er-1 .. er+g-2.
  task automatic push_exp(input int er, input int g);
    logic [NUM_CH*CNT_W-1:0] c;
    logic [NUM_CH-1:0]       o;
    int                      raw;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      raw = 0;
      for (int t = er - 1; t <= er + g - 2; t++) raw += int'(rose[ch][t]);
      c[ch*CNT_W +: CNT_W] = (raw > CMAX) ? CNT_W'(CMAX) : CNT_W'(raw);
      o[ch] = (raw > CMAX);
    end
    model_id = (model_id + 1) % 256;
    q_due.push_back(er + g + 2);
    q_id.push_back(model_id);
    q_cnt.push_back(c);
    q_ovf.push_back(o);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      drive_ro(cyc);
      start    = 1'b0;
      cont     = 1'b0;
      gate_len = GATE_W'($urandom_range(0, 255));
      rd_ch    = RD_W'($urandom_range(0, 3));
    end
  endtask

  task automatic ignore_txn();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_ro(cyc);
      start    = 1'b1;
      gate_len = '0;
      rd_ch    = RD_W'($urandom_range(0, 3));
    end
    @(negedge clk);
    drive_ro(cyc);
    ena      = 1'b0;
    gate_len = GATE_W'(9);
    @(negedge clk);
    drive_ro(cyc);
    ena   = 1'b1;
    start = 1'b0;
  endtask

  // One measurement (r_n runs of g cycles); ab_run >= 0 kills that run via ena, or via rst_n if by_rst.
  task automatic run_txn(input int g, input int r_n, input int ab_run, input bit by_rst);
    int n, p, e0, ab, l_last, stop_n, er;
    bit abort;
    @(negedge clk);
    n      = cyc;
    e0     = n + 1;
    abort  = (ab_run >= 0);
    ab     = abort ? (e0 + ab_run * (g + 2) + 1 + int'($urandom_range(0, g - 1))) : -1;
    l_last = e0 + r_n * (g + 2);
    b_start = e0;
    b_end   = abort ? ab : (l_last - 1);
    stop_n  = abort ? (ab + 5) : (l_last + 2);
    while (1) begin
      if (by_rst && (n >= ab) && (n <= ab + 2)) begin
        ro_in = '0;
        rst_n = (n == ab + 2);
        if (n == ab) model_id = 0;
      end else begin
        drive_ro(n);
      end
      p        = n + 1;
      start    = (p == e0) || ((n >= e0) && (n <= b_end) && ($urandom_range(0, 3) == 0));
      cont     = (r_n > 1) && (p < l_last);
      ena      = !(abort && !by_rst && (p == ab + 1));
      gate_len = ((p == e0) || ((n >= e0) && (((n - e0) % (g + 2)) == 0))) ?
                 GATE_W'(g) : GATE_W'($urandom_range(0, 255));
      rd_ch    = RD_W'($urandom_range(0, 3));
      for (int r = 0; r < r_n; r++) begin
        er = e0 + r * (g + 2);
        if ((n == er + g - 1) && (!abort || (r < ab_run))) push_exp(er, g);
      end
      if (n >= stop_n) break;
      @(negedge clk);
      n = cyc;
    end
    start = 1'b0;
    cont  = 1'b0;
    ena   = 1'b1;
  endtask

  // Monitor / scoreboard
  initial begin
    int due, id, last_id;
    logic [NUM_CH*CNT_W-1:0] cv;
    logic [NUM_CH-1:0]       ov;
    last_id = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      exp_res[ch] = '0;
      exp_ovf[ch] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_rd_ovf", int'(rd_ovf), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_meas_id", int'(meas_id), 0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
          exp_res[ch] = '0;
          exp_ovf[ch] = 1'b0;
        end
        last_id = 0;
      end else begin
        chk("busy", int'(busy), ((cyc >= b_start) && (cyc <= b_end)) ? 1 : 0);
        if (int'(rd_ch) < NUM_CH) begin
          chk("rd_data", int'(rd_data), int'(exp_res[rd_ch]));
          chk("rd_ovf", int'(rd_ovf), int'(exp_ovf[rd_ch]));
        end else begin
          chk("rd_data_oob", int'(rd_data), 0);
          chk("rd_ovf_oob", int'(rd_ovf), 0);
        end
        if (done) begin
          if (q_due.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            due = q_due.pop_front();
            id  = q_id.pop_front();
            cv  = q_cnt.pop_front();
            ov  = q_ovf.pop_front();
            chk("done_time", cyc, due);
            chk("meas_id_done", int'(meas_id), id);
            last_id = id;
            for (int ch = 0; ch < NUM_CH; ch++) begin
              exp_res[ch] = cv[ch*CNT_W +: CNT_W];
              exp_ovf[ch] = ov[ch];
            end
            $display("meas id=%0d cyc=%0d cnt=%h ovf=%b", id, cyc, cv, ov);
          end
        end else begin
          chk("meas_id_hold", int'(meas_id), last_id);
          if ((q_due.size() > 0) && (cyc > q_due[0])) begin
            chk("done_missing", cyc, q_due[0]);
            void'(q_due.pop_front());
            void'(q_id.pop_front());
            void'(q_cnt.pop_front());
            void'(q_ovf.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, r, ab;
    bit br;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      mode[ch] = 0; per[ch] = 1; ph[ch] = 0; stat[ch] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
    idle(5);

    // Single shot: ch0 rises every 4 cycles, ch1 every 8, ch2 static.
    mode[0] = 1; per[0] = 2;
    mode[1] = 1; per[1] = 4;
    mode[2] = 0; stat[2] = 1'b0;
    run_txn(100, 1, -1, 1'b0);
    idle(3);

    // Saturation: ch0 toggles every cycle.
    rand_modes();
    mode[0] = 1; per[0] = 1; ph[0] = 0;
    run_txn(64, 1, -1, 1'b0);
    idle(3);

    rand_modes();
    run_txn(10, 4, -1, 1'b0);
    idle(2);

    rand_modes();
    run_txn(30, 1, 0, 1'b0);
    idle(2);

    ignore_txn();
    idle(2);

    rand_modes();
    mode[0] = 1; per[0] = 1;
    run_txn(40, 1, 0, 1'b1);
    idle(3);

    rand_modes();
    run_txn(8, 3, 1, 1'b0);
    idle(2);

    for (int i = 0; i < 25; i++) begin
      rand_modes();
      g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 120));
      r  = int'($urandom_range(1, 4));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, r - 1)) : -1;
      br = (ab >= 0) && ($urandom_range(0, 1) == 1);
      run_txn(g, r, ab, br);
      idle(int'($urandom_range(1, 4)));
    end

    // Long continuous burst so meas_id wraps through 255 -> 0.
    rand_modes();
    run_txn(int'($urandom_range(1, 3)), 260, -1, 1'b0);
    idle(10);

    chk("queue_empty", q_due.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
